// File: rtl/axi_burst_pkg.sv
// Shared types and helpers for the AXI burst write subordinate.
// Holds the burst/state enums, response codes and the next-beat address rule.
// No logic state lives here; everything is combinational.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Working width for address arithmetic; callers zero-extend and truncate.
  localparam int NA_W = 32;

  // Address of the beat following 'addr'. INCR/WRAP step from the size-aligned
  // address; WRAP keeps the result inside the (len+1)*2^size aligned window.
  function automatic logic [NA_W-1:0] next_addr(input logic [NA_W-1:0] addr,
                                                input logic [2:0]      size,
                                                input logic [7:0]      len,
                                                input burst_e          burst);
    logic [NA_W-1:0] incr;
    logic [NA_W-1:0] aligned;
    logic [NA_W-1:0] stepped;
    logic [NA_W-1:0] wmask;
    incr    = NA_W'(1) << size;
    aligned = addr & ~(incr - NA_W'(1));
    stepped = aligned + incr;
    wmask   = ((NA_W'(len) + NA_W'(1)) << size) - NA_W'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (aligned & ~wmask) | (stepped & wmask);
      default:     next_addr = stepped;
    endcase
  endfunction

endpackage

// File: rtl/axi_burst_mem.sv
// Word storage with a byte-enable write port and a registered read port.
// Write lands on the clock edge; read data appears one cycle after raddr.
// No backpressure: every write/read request is serviced each cycle.
module axi_burst_mem
  import axi_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [$clog2(MEM_DEPTH)-1:0]  widx,
  input  logic [DATA_WIDTH/8-1:0]       wbe,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read the array combinationally; the register below gives the 1-cycle latency.
  always_comb begin
    rdata_d = mem_q[raddr];
  end

  // Read register; a same-cycle write is not visible until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Byte-lane writes; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wbe[b]) begin
          mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_burst_wr_sub.sv
// AXI write subordinate: one burst at a time into local word memory.
// AW->W 1 cycle, last W->B 1 cycle, B->AW 1 cycle; all handshake outputs registered.
// Holds B until bready; AW/W stay not-ready outside their own phase.
module axi_burst_wr_sub
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [ID_WIDTH-1:0]           awid,
  input  logic [ADDR_WIDTH-1:0]         awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  input  logic                          wlast,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [ID_WIDTH-1:0]           bid,
  output logic [1:0]                    bresp,
  input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_raddr,
  output logic [DATA_WIDTH-1:0]         dbg_rdata
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(BYTE_LSB);

  state_e                state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  burst_e                burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic                  err_q, err_d;

  logic                  aw_err;
  logic                  is_last;
  logic                  mem_we;

  // Next state, burst bookkeeping and the registered handshake outputs.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    is_last   = (beat_q == len_q);
    aw_err    = (awsize > MAX_SIZE) ||
                (awburst == BURST_RSVD) ||
                ((awburst == BURST_WRAP) &&
                 !((awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15)));

    case (state_q)
      ST_IDLE: begin
        if (awvalid && awready_q) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = burst_e'(awburst);
          beat_d  = 8'd0;
          err_d   = aw_err;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wvalid && wready_q) begin
          // A burst flagged at AW time swallows its beats without writing.
          mem_we = aresetn && !err_q;
          if (wlast || is_last) begin
            // wlast and the beat count must agree; either mismatch is an error.
            if (wlast != is_last) begin
              err_d = 1'b1;
            end
            state_d = ST_RESP;
            bid_d   = id_q;
            bresp_d = err_d ? RESP_SLVERR : RESP_OKAY;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = ADDR_WIDTH'(next_addr(NA_W'(addr_q), size_q, len_q, burst_q));
          end
        end
      end
      ST_RESP: begin
        if (bvalid_q && bready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    awready_d = (state_d == ST_IDLE);
    wready_d  = (state_d == ST_DATA);
    bvalid_d  = (state_d == ST_RESP);
  end

  // State and output registers; ready/valid stay low throughout reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      beat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

  axi_burst_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (mem_we),
    .widx  (addr_q[IDX_W+BYTE_LSB-1:BYTE_LSB]),
    .wbe   (wstrb),
    .wdata (wdata),
    .raddr (dbg_raddr),
    .rdata (dbg_rdata)
  );

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

endmodule
